ahb_apb_arbiter: RTL and testbench
==================================

AHB_APB_ARBITER -- requirements
Module: ahb_apb_arbiter

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 14, giving the HADDR and request address width (matches the APB bridge).
REQ-002 SHALL have ports: HCLK  in  1  clock; HRESETn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have, for n in {0,1}: req_n  in  1  transfer request, held until done_n; addr_n  in  ADDRWIDTH  byte address; write_n  in  1  1=write; size_n  in  2  0=byte, 1=hword, 2=word; wdata_n  in  32  write data.
REQ-004 SHALL have, for n in {0,1}: done_n  out  1  single-cycle completion pulse.
REQ-005 SHALL have rsp_rdata  out  32  read data, valid with done_n; rsp_err  out  1  error, valid with done_n; busy  out  1  transfer in flight.
REQ-006 SHALL have AHB master ports to the bridge: HSEL, HADDR[ADDRWIDTH], HTRANS[2], HSIZE[3], HPROT[4], HWRITE, HREADY, HWDATA[32] out; HREADYOUT, HRDATA[32], HRESP in.

Function
REQ-007 SHALL run a state machine with states IDLE, ADDR and DATA.
REQ-008 IDLE: if any eligible request exists, SHALL latch the winner's addr, write, size and wdata plus a winner id, then go to ADDR; otherwise stay in IDLE.
REQ-009 SHALL treat req_n as eligible only while done_n is low, so a requester is not re-granted in its own done cycle.
REQ-010 ADDR: SHALL drive HSEL=1, HTRANS=2'b10 (NONSEQ), HADDR=latched address, HWRITE=latched write, HSIZE={1'b0,size}, HPROT=4'b0011.
REQ-011 SHALL go ADDR->DATA on the edge where HREADYOUT=1; otherwise SHALL hold ADDR with all address-phase signals stable.
REQ-012 DATA: SHALL drive HSEL=0, HTRANS=2'b00 and HWDATA=latched wdata.
REQ-013 SHALL hold DATA while HREADYOUT=0.
REQ-014 On the edge where HREADYOUT=1 in DATA, SHALL register rsp_rdata<=HRDATA (reads only; otherwise hold the previous value) and rsp_err<=HRESP.
REQ-015 On that same edge, SHALL pulse done_<winner> high for exactly the following cycle and return to IDLE.
REQ-016 A two-cycle bridge ERROR response (HRESP=1 with HREADYOUT=0, then HRESP=1 with HREADYOUT=1) SHALL yield rsp_err=1; no retry SHALL be issued.
REQ-017 HREADY SHALL equal HREADYOUT combinationally (single-slave bus).
REQ-018 busy SHALL be 1 in ADDR and DATA and 0 in IDLE.
REQ-019 If req_n is deasserted mid-transfer, the transfer SHALL still complete and done_n SHALL still pulse.
REQ-020 Back-to-back transfers: minimum one IDLE cycle between done and the next ADDR; minimum transfer latency from req to done is 3 cycles.

Reset
REQ-021 While HRESETn=0, SHALL hold state=IDLE, HSEL=0, HTRANS=0, HADDR=0, HWRITE=0, HSIZE=0, HPROT=4'b0011, HWDATA=0, done_n=0, rsp_rdata=0, rsp_err=0, busy=0, and round-robin pointer=1 (so requester 0 wins first).
REQ-022 Reset asserted mid-transfer SHALL abort it with no done pulse.

Configuration
REQ-023 With macro AHB_APB_ARB_RR_EN defined: round-robin arbitration; on a tie the grant SHALL go to the requester not granted last, and the pointer SHALL update on every grant.
REQ-024 Without AHB_APB_ARB_RR_EN: fixed priority, requester 0 always wins a tie, and no pointer register SHALL exist.

Verification
REQ-025 Single read: req_0 with addr_0=0x0010 and a bridge returning HRDATA=0xCAFE0001, HRESP=0 -> one NONSEQ with HADDR=0x0010 and HWRITE=0, then done_0=1 for 1 cycle with rsp_rdata=0xCAFE0001 and rsp_err=0.
REQ-026 Byte write: req_1 with write_1=1, size_1=0, addr_1=0x0003, wdata_1=0x000000AB -> HSIZE=3'b000 in ADDR, HWDATA=0x000000AB in DATA, then done_1 pulse.
REQ-027 Error: bridge returns the two-cycle ERROR response -> rsp_err=1 with done pulse, then next transfer proceeds normally with rsp_err=0.
REQ-028 Tie, RR_EN defined: req_0 and req_1 held high for 4 transfers -> grant order 0,1,0,1. Without the macro -> order 0,0,0,0.
REQ-029 Wait states: HREADYOUT held 0 for 5 DATA cycles -> HSEL=0, HTRANS=0 and HWDATA stable throughout; done pulses only after HREADYOUT=1.
REQ-030 Reset in DATA: HRESETn=0 during DATA -> all outputs take their reset values immediately and no done pulse is issued.

Source files
------------

// File: rtl/ahb_apb_arbiter.sv
// ahb_apb_arbiter: grants one of two requesters and runs a single AHB transfer into the APB bridge.
// Define AHB_APB_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module ahb_apb_arbiter #(
  parameter int ADDRWIDTH = 14
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 req_0,
  input  logic [ADDRWIDTH-1:0] addr_0,
  input  logic                 write_0,
  input  logic [1:0]           size_0,
  input  logic [31:0]          wdata_0,
  input  logic                 req_1,
  input  logic [ADDRWIDTH-1:0] addr_1,
  input  logic                 write_1,
  input  logic [1:0]           size_1,
  input  logic [31:0]          wdata_1,
  output logic                 done_0,
  output logic                 done_1,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 HSEL,
  output logic [ADDRWIDTH-1:0] HADDR,
  output logic [1:0]           HTRANS,
  output logic [2:0]           HSIZE,
  output logic [3:0]           HPROT,
  output logic                 HWRITE,
  output logic                 HREADY,
  output logic [31:0]          HWDATA,
  input  logic                 HREADYOUT,
  input  logic [31:0]          HRDATA,
  input  logic                 HRESP
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t               state_q, state_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [1:0]           size_q, size_d, done_q, done_d;
  logic [31:0]          wdata_q, wdata_d, rdata_q, rdata_d;
  logic                 write_q, write_d, id_q, id_d, err_q, err_d;
  logic                 el_0, el_1, gnt_1, grant;
  // No grant in a done cycle: the finishing requester still holds req, and this gives the IDLE gap.
  assign el_0  = req_0 & ~|done_q;
  assign el_1  = req_1 & ~|done_q;
  assign grant = (state_q == IDLE) & (el_0 | el_1);
`ifdef AHB_APB_ARB_RR_EN
  logic ptr_q, ptr_d;
  assign gnt_1 = el_1 & (~el_0 | ~ptr_q);
  assign ptr_d = grant ? gnt_1 : ptr_q;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) ptr_q <= 1'b1;
    else ptr_q <= ptr_d;
`else
  assign gnt_1 = el_1 & ~el_0;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    id_d    = id_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    done_d  = 2'b00;
    if (grant) begin
      state_d = ADDR;
      id_d    = gnt_1;
      addr_d  = gnt_1 ? addr_1 : addr_0;
      write_d = gnt_1 ? write_1 : write_0;
      size_d  = gnt_1 ? size_1 : size_0;
      wdata_d = gnt_1 ? wdata_1 : wdata_0;
    end
    if (state_q == ADDR && HREADYOUT) state_d = DATA;
    if (state_q == DATA && HREADYOUT) begin
      state_d = IDLE;
      rdata_d = write_q ? rdata_q : HRDATA;
      err_d   = HRESP;
      done_d  = id_q ? 2'b10 : 2'b01;
    end
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      wdata_q <= '0;
      id_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      id_q    <= id_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  assign HSEL      = state_q == ADDR;
  assign HTRANS    = HSEL ? 2'b10 : 2'b00;
  assign HADDR     = addr_q;
  assign HWRITE    = write_q;
  assign HSIZE     = {1'b0, size_q};
  assign HPROT     = 4'b0011;
  assign HWDATA    = wdata_q;
  assign HREADY    = HREADYOUT;
  assign busy      = state_q != IDLE;
  assign done_0    = done_q[0];
  assign done_1    = done_q[1];
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
endmodule

// File: tb/tb_ahb_apb_arbiter.sv
// tb_ahb_apb_arbiter: table vectors, randomized transfers against a transaction-level model, reset and tie sequences.
module tb_ahb_apb_arbiter;
  localparam int AW = 14;
  logic          HCLK = 1'b0, HRESETn;
  logic          req_0, req_1, write_0, write_1;
  logic [AW-1:0] addr_0, addr_1;
  logic [1:0]    size_0, size_1;
  logic [31:0]   wdata_0, wdata_1;
  logic          done_0, done_1, rsp_err, busy;
  logic [31:0]   rsp_rdata;
  logic          HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic [3:0]    HPROT;
  logic [31:0]   HWDATA, HRDATA;
  int vectors = 0;
  int miscompares = 0;
  always #5 HCLK = ~HCLK;
  ahb_apb_arbiter #(.ADDRWIDTH(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_0(req_0), .addr_0(addr_0), .write_0(write_0), .size_0(size_0), .wdata_0(wdata_0),
    .req_1(req_1), .addr_1(addr_1), .write_1(write_1), .size_1(size_1), .wdata_1(wdata_1),
    .done_0(done_0), .done_1(done_1), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT),
    .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP)
  );
  typedef struct {
    logic          n;
    logic [AW-1:0] a;
    logic          w;
    logic [1:0]    s;
    logic [31:0]   wd;
    int            aw;
    int            dw;
    logic [31:0]   rd;
    logic          er;
    logic          drop;
    logic [2:0]    exp_hsize;
    logic [31:0]   exp_rd;
    logic          exp_err;
  } vec_t;
  vec_t tbl[7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_hsel"}, 32'(HSEL), 0);
    chk({tag, "_htrans"}, 32'(HTRANS), 0);
    chk({tag, "_haddr"}, 32'(HADDR), 0);
    chk({tag, "_hwrite"}, 32'(HWRITE), 0);
    chk({tag, "_hsize"}, 32'(HSIZE), 0);
    chk({tag, "_hprot"}, 32'(HPROT), 32'h3);
    chk({tag, "_hwdata"}, HWDATA, 0);
    chk({tag, "_done"}, 32'({done_1, done_0}), 0);
    chk({tag, "_rdata"}, rsp_rdata, 0);
    chk({tag, "_err"}, 32'(rsp_err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask
  // Runs one isolated transfer, starting and ending just after a falling edge.
  task automatic xfer(input vec_t v);
    logic [1:0] exp_done;
    exp_done = v.n ? 2'b10 : 2'b01;
    if (v.n) begin req_1 = 1; addr_1 = v.a; write_1 = v.w; size_1 = v.s; wdata_1 = v.wd; end
    else begin req_0 = 1; addr_0 = v.a; write_0 = v.w; size_0 = v.s; wdata_0 = v.wd; end
    HREADYOUT = 1'b1;
    HRESP = 1'b0;
    for (int i = 0; i <= v.aw; i++) begin
      @(negedge HCLK);
      HREADYOUT = (i == v.aw);
      HRDATA = $urandom;
      if (v.drop) begin req_0 = 0; req_1 = 0; end
      #1;
      chk("addr_hsel", 32'(HSEL), 1);
      chk("addr_htrans", 32'(HTRANS), 32'h2);
      chk("addr_haddr", 32'(HADDR), 32'(v.a));
      chk("addr_hwrite", 32'(HWRITE), 32'(v.w));
      chk("addr_hsize", 32'(HSIZE), 32'(v.exp_hsize));
      chk("addr_hprot", 32'(HPROT), 32'h3);
      chk("addr_busy", 32'(busy), 1);
      chk("hready", 32'(HREADY), 32'(HREADYOUT));
    end
    for (int i = 0; i <= v.dw; i++) begin
      @(negedge HCLK);
      HREADYOUT = (i == v.dw);
      HRESP = v.er && (i + 1 >= v.dw);
      HRDATA = (i == v.dw) ? v.rd : $urandom;
      #1;
      chk("data_hsel", 32'(HSEL), 0);
      chk("data_htrans", 32'(HTRANS), 0);
      chk("data_hwdata", HWDATA, v.wd);
      chk("data_busy", 32'(busy), 1);
      chk("data_no_done", 32'({done_1, done_0}), 0);
    end
    @(negedge HCLK);
    HREADYOUT = 1'b1;
    HRESP = 1'b0;
    chk("done", 32'({done_1, done_0}), 32'(exp_done));
    chk("rsp_rdata", rsp_rdata, v.exp_rd);
    chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    chk("done_busy", 32'(busy), 0);
    req_0 = 0;
    req_1 = 0;
    @(negedge HCLK);
    chk("done_width", 32'({done_1, done_0}), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t v;
    logic [31:0] model_rd;
    int exp_order[4];
    int got, cyc;
    HRESETn = 0;
    {req_0, req_1, write_0, write_1} = '0;
    {addr_0, addr_1, size_0, size_1, wdata_0, wdata_1} = '0;
    HREADYOUT = 1; HRDATA = 0; HRESP = 0;
    repeat (3) @(negedge HCLK);
    chk_reset("rst");
    HRESETn = 1;
    @(negedge HCLK);
    tbl[0] = '{1'b0, 14'h0010, 1'b0, 2'd2, 32'h0, 0, 0, 32'hCAFE0001, 1'b0, 1'b0, 3'b010, 32'hCAFE0001, 1'b0};
    tbl[1] = '{1'b1, 14'h0003, 1'b1, 2'd0, 32'h000000AB, 0, 0, 32'h11111111, 1'b0, 1'b0, 3'b000, 32'hCAFE0001, 1'b0};
    tbl[2] = '{1'b0, 14'h0020, 1'b0, 2'd1, 32'h0, 1, 1, 32'hDEAD0002, 1'b1, 1'b0, 3'b001, 32'hDEAD0002, 1'b1};
    tbl[3] = '{1'b1, 14'h0024, 1'b0, 2'd2, 32'h0, 0, 0, 32'h12345678, 1'b0, 1'b1, 3'b010, 32'h12345678, 1'b0};
    tbl[4] = '{1'b0, 14'h0100, 1'b1, 2'd2, 32'hA5A5A5A5, 0, 5, 32'h0, 1'b0, 1'b0, 3'b010, 32'h12345678, 1'b0};
    tbl[5] = '{1'b1, 14'h3FFF, 1'b1, 2'd1, 32'h5A5A1234, 0, 1, 32'hFFFFFFFF, 1'b1, 1'b0, 3'b001, 32'h12345678, 1'b1};
    tbl[6] = '{1'b0, 14'h2000, 1'b0, 2'd2, 32'h0, 3, 2, 32'h0BADF00D, 1'b0, 1'b1, 3'b010, 32'h0BADF00D, 1'b0};
    for (int i = 0; i < 7; i++) xfer(tbl[i]);
    model_rd = 32'h0BADF00D;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge HCLK);
      v.n = 1'($urandom_range(0, 1));
      v.a = AW'($urandom);
      v.w = 1'($urandom_range(0, 1));
      v.s = 2'($urandom_range(0, 2));
      v.wd = $urandom;
      v.aw = $urandom_range(0, 2);
      v.dw = $urandom_range(0, 3);
      v.rd = $urandom;
      v.er = 1'($urandom_range(0, 1));
      v.drop = 1'($urandom_range(0, 1));
      v.exp_hsize = {1'b0, v.s};
      v.exp_rd = v.w ? model_rd : v.rd;
      v.exp_err = v.er;
      model_rd = v.exp_rd;
      xfer(v);
    end
    req_0 = 1; addr_0 = 14'h0040; write_0 = 0; size_0 = 2'd2; wdata_0 = 32'h0;
    HREADYOUT = 1;
    @(negedge HCLK);
    @(negedge HCLK);
    HREADYOUT = 0;
    #1;
    chk("pre_abort_busy", 32'(busy), 1);
    HRESETn = 0;
    #1;
    chk_reset("abort");
    req_0 = 0;
    HREADYOUT = 1;
    repeat (2) begin
      @(negedge HCLK);
      chk("abort_no_done", 32'({done_1, done_0}), 0);
      chk("abort_busy", 32'(busy), 0);
    end
    HRESETn = 1;
    @(negedge HCLK);
`ifdef AHB_APB_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    req_0 = 1; addr_0 = 14'h0100; write_0 = 0; size_0 = 2'd2;
    req_1 = 1; addr_1 = 14'h0200; write_1 = 0; size_1 = 2'd2;
    HRDATA = 32'h55AA55AA;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 60) begin
      @(negedge HCLK);
      cyc++;
      if (done_0 || done_1) begin
        chk("tie_order", 32'(done_1), 32'(exp_order[got]));
        chk("tie_single_done", 32'(done_0 & done_1), 0);
        got++;
        if (got == 4) begin req_0 = 0; req_1 = 0; end
      end
    end
    chk("tie_count", 32'(got), 4);
    @(negedge HCLK);
    chk("tie_idle", 32'(busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
